// File: rtl/chan_mux_scan_if.sv
// chan_mux_scan_if: channel words, run/mode/select controls and the registered
// selected-word outputs of chan_mux_scan.
interface chan_mux_scan_if #(
  parameter int WIDTH = 5,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic enable;
  logic mode;
  logic [SELW-1:0] sel;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_ch;
  logic out_valid;
  logic [CHANNELS-1:0] ch_onehot;
  logic scan_wrap;
  modport master (
    output ch_data, enable, mode, sel,
    input out_data, out_ch, out_valid, ch_onehot, scan_wrap
  );
  modport slave (
    input ch_data, enable, mode, sel,
    output out_data, out_ch, out_valid, ch_onehot, scan_wrap
  );
endinterface

// File: rtl/chan_mux_scan.sv
// chan_mux_scan: registered N-channel word mux, manual select or timed auto-scan.
// Define CHAN_MUX_BLANK_EN to blank the outputs for one cycle on every index change.
module chan_mux_scan #(
  parameter int WIDTH = 5,
  parameter int CHANNELS = 4,
  parameter int SCAN_DIV = 16
) (
  input logic clk,
  input logic rst_n,
  chan_mux_scan_if.slave bus
);
  localparam int SELW = $clog2(CHANNELS);
  localparam int PW = $clog2(SCAN_DIV);
  logic [SELW-1:0] idx, nidx;
  logic [PW-1:0] pre, pcur, npre;
  logic mode_q, adv, last, wrap, ok, show;
  logic [WIDTH-1:0] word;
`ifdef CHAN_MUX_BLANK_EN
  logic pend;
`endif
  // an out-of-range index left over from manual mode restarts the scan at channel 0
  always_comb begin
    pcur = mode_q ? pre : '0;
    adv = bus.mode && pcur == PW'(SCAN_DIV - 1);
    npre = (!bus.mode || adv) ? '0 : pcur + PW'(1);
    last = idx == SELW'(CHANNELS - 1);
    nidx = !bus.mode ? bus.sel : 32'(idx) >= CHANNELS ? '0 : adv ? (last ? '0 : idx + SELW'(1)) : idx;
    wrap = adv && last;
    ok = 32'(nidx) < CHANNELS;
    word = bus.ch_data[32'(nidx) * WIDTH +: WIDTH];
`ifdef CHAN_MUX_BLANK_EN
    show = ok && nidx == idx;
`else
    show = ok;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      pre <= '0;
      mode_q <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch <= '0;
      bus.out_valid <= 1'b0;
      bus.ch_onehot <= '0;
      bus.scan_wrap <= 1'b0;
`ifdef CHAN_MUX_BLANK_EN
      pend <= 1'b0;
`endif
    end else if (bus.enable) begin
      idx <= nidx;
      pre <= npre;
      mode_q <= bus.mode;
      bus.out_valid <= show;
      bus.out_data <= show ? word : '0;
      bus.ch_onehot <= show ? CHANNELS'(1) << nidx : '0;
      if (show) bus.out_ch <= nidx;
`ifdef CHAN_MUX_BLANK_EN
      pend <= wrap;
      bus.scan_wrap <= pend && bus.mode;
`else
      bus.scan_wrap <= wrap;
`endif
    end else begin
      bus.scan_wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_chan_mux_scan.sv
// tb_chan_mux_scan: randomized checks of chan_mux_scan (3 channels, non-power-of-2)
// against a reference model that derives the channel from elapsed scan time.
module tb_chan_mux_scan;
  localparam int W = 5, CH = 3, DIV = 16, SW = $clog2(CH), DW = CH * W;
  localparam int OW = W + SW + CH + 2;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  chan_mux_scan_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
  chan_mux_scan #(.WIDTH(W), .CHANNELS(CH), .SCAN_DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  int m_ch, m_start, m_t;
  bit m_scan, m_pend;
  logic [W-1:0] e_data;
  logic [SW-1:0] e_ch;
  logic e_valid, e_wrap;
  logic [CH-1:0] e_oh;
  function automatic logic [OW-1:0] obs();
    return {bus.out_data, bus.out_ch, bus.out_valid, bus.ch_onehot, bus.scan_wrap};
  endfunction
  function automatic logic [OW-1:0] expv();
    return {e_data, e_ch, e_valid, e_oh, e_wrap};
  endfunction
  task automatic model_reset();
    m_ch = 0; m_start = 0; m_t = 0; m_scan = 0; m_pend = 0;
    e_data = '0; e_ch = '0; e_valid = 0; e_oh = '0; e_wrap = 0;
  endtask
  // channel in scan = start + elapsed scan cycles / DIV, modulo CH
  task automatic tick();
    int prev;
    bit adv, w, blank, v;
    logic [DW-1:0] d;
    @(posedge clk);
    prev = m_ch; adv = 0; d = bus.ch_data;
    if (bus.enable) begin
      if (!bus.mode) begin
        m_ch = int'(bus.sel); m_scan = 0;
      end else begin
        if (!m_scan) begin m_start = (m_ch >= CH) ? 0 : m_ch; m_t = 0; m_scan = 1; end
        m_t++;
        m_ch = (m_start + m_t / DIV) % CH;
        adv = (m_t % DIV) == 0;
      end
      w = adv && m_ch == 0;
`ifdef CHAN_MUX_BLANK_EN
      blank = m_ch != prev;
      e_wrap = m_pend && bus.mode; m_pend = w;
`else
      blank = 0; e_wrap = w;
`endif
      v = m_ch < CH && !blank;
      e_valid = v;
      e_data = v ? d[m_ch*W +: W] : '0;
      e_oh = v ? CH'(1) << m_ch : '0;
      if (v) e_ch = SW'(m_ch);
    end else e_wrap = 0;
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0; bus.enable = 1; bus.mode = 0; bus.sel = 2;
    bus.ch_data = {5'd2, 5'd1, 5'd0};
    model_reset();
    #12;
    if (obs() !== '0) begin errors++; $display("FAIL reset_state got %h exp 0", obs()); end
    checks++;
    @(negedge clk) rst_n = 1;
    tick();
    if ({bus.out_data, bus.out_ch, bus.out_valid, bus.ch_onehot} !== {5'd2, 2'd2, 1'b1, 3'b100}) begin
      errors++; $display("FAIL reset_first_sel got data=%0d ch=%0d v=%b oh=%b exp 2 2 1 100", bus.out_data, bus.out_ch, bus.out_valid, bus.ch_onehot);
    end
    checks++;
    if (obs() !== expv()) begin errors++; $display("FAIL reset_model got %h exp %h", obs(), expv()); end
    checks++;
  endtask
  task automatic test_manual();
    bus.enable = 1; bus.mode = 0;
    for (int i = 0; i < 60; i++) begin
      bus.sel = SW'($urandom_range(0, 3));
      bus.ch_data = DW'($urandom);
      tick();
      if (obs() !== expv()) begin errors++; $display("FAIL manual c%0d sel=%0d got %h exp %h", i, bus.sel, obs(), expv()); end
      checks++;
    end
  endtask
  task automatic test_scan();
    int last_wrap = -1, wraps = 0, ewraps = 0;
    bus.enable = 1; bus.mode = 1; bus.sel = 0;
    for (int i = 0; i < 4 * CH * DIV; i++) begin
      if ($urandom_range(0, 7) == 0) bus.ch_data = DW'($urandom);
      tick();
      if (obs() !== expv()) begin errors++; $display("FAIL scan c%0d got %h exp %h", i, obs(), expv()); end
      checks++;
      if (bus.out_valid && int'(bus.out_ch) >= CH) begin errors++; $display("FAIL scan_range c%0d got ch=%0d exp <%0d", i, bus.out_ch, CH); end
      checks++;
      if (e_wrap) ewraps++;
      if (bus.scan_wrap) begin
        wraps++;
        if (last_wrap >= 0) begin
          if (i - last_wrap != CH * DIV) begin errors++; $display("FAIL wrap_period got %0d exp %0d", i - last_wrap, CH * DIV); end
          checks++;
        end
        last_wrap = i;
      end
    end
    if (wraps != ewraps || wraps < 3) begin errors++; $display("FAIL wrap_count got %0d exp %0d", wraps, ewraps); end
    checks++;
  endtask
  task automatic test_enable();
    int n = 0;
    logic [SW-1:0] ch0;
    bus.enable = 1; bus.mode = 1;
    for (int i = 0; i < 100 && !(m_scan && m_t % DIV == 5); i++) begin
      tick();
      if (obs() !== expv()) begin errors++; $display("FAIL enable_pre c%0d got %h exp %h", i, obs(), expv()); end
      checks++;
    end
    bus.enable = 0;
    for (int i = 0; i < 10; i++) begin
      bus.ch_data = DW'($urandom);
      tick();
      if (obs() !== expv()) begin errors++; $display("FAIL enable_frozen c%0d got %h exp %h", i, obs(), expv()); end
      checks++;
    end
    bus.enable = 1; ch0 = bus.out_ch;
    while (n < 40 && bus.out_ch == ch0) begin
      tick(); n++;
      if (obs() !== expv()) begin errors++; $display("FAIL enable_resume c%0d got %h exp %h", n, obs(), expv()); end
      checks++;
    end
    if (n != DIV - 5) begin errors++; $display("FAIL enable_dwell got %0d exp %0d", n, DIV - 5); end
    checks++;
    for (int i = 0; i < 100; i++) begin
      bus.enable = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) == 0) bus.ch_data = DW'($urandom);
      tick();
      if (obs() !== expv()) begin errors++; $display("FAIL enable_rand c%0d en=%b got %h exp %h", i, bus.enable, obs(), expv()); end
      checks++;
    end
  endtask
  task automatic test_mode_switch();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 3) == 0) bus.sel = SW'($urandom_range(0, 3));
      bus.enable = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 3) == 0) bus.ch_data = DW'($urandom);
      tick();
      if (obs() !== expv()) begin errors++; $display("FAIL mode_switch c%0d m=%b s=%0d got %h exp %h", i, bus.mode, bus.sel, obs(), expv()); end
      checks++;
    end
  endtask
  task automatic test_async_reset();
    int n = 0;
    bus.enable = 1; bus.mode = 1; bus.sel = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs() !== expv()) begin errors++; $display("FAIL ares_pre c%0d got %h exp %h", i, obs(), expv()); end
      checks++;
    end
    #2 rst_n = 0;
    #1;
    if (obs() !== '0) begin errors++; $display("FAIL ares_async got %h exp 0", obs()); end
    checks++;
    model_reset();
    #2 rst_n = 1;
    while (n < 40 && !(bus.out_valid && bus.out_ch == 1)) begin
      tick(); n++;
      if (obs() !== expv()) begin errors++; $display("FAIL ares_rescan c%0d got %h exp %h", n, obs(), expv()); end
      checks++;
    end
    if (n != DIV) begin errors++; $display("FAIL ares_first_adv got %0d exp %0d", n, DIV); end
    checks++;
  endtask
  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_enable();
    test_mode_switch();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
